// File: rtl/pool_window_reader_pkg.sv
// Shared types and sizing helpers for the pooling-bank readers.
// Imported by the window reader, the pool datapath and the next-layer reader.
package pool_window_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Width of the window/element counters; covers maps up to 64k pixels per side.
  localparam int unsigned CntW = 16;

  function automatic int unsigned out_dim(input int unsigned size, input int unsigned k,
                                          input int unsigned stride);
    return (size - k) / stride + 1;
  endfunction

  function automatic int unsigned frame_beats(input int unsigned img_w, input int unsigned img_h,
                                              input int unsigned k, input int unsigned stride);
    return out_dim(img_w, k, stride) * out_dim(img_h, k, stride) * k * k;
  endfunction

endpackage

// File: rtl/pool_skid_fifo.sv
// Two-entry FIFO whose head entry is a register that drives the output directly,
// so the presented beat never changes while it waits to be popped.
module pool_skid_fifo #(
  parameter int unsigned Width = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] head_q;
  logic [Width-1:0] tail_q;
  logic [1:0]       count_q;
  logic             rd_ok;
  logic             wr_ok;

  assign rd_ok = rd_en && (count_q != 2'd0);
  assign wr_ok = wr_en && ((count_q != 2'd2) || rd_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({wr_ok, rd_ok})
        2'b10: begin
          if (count_q == 2'd0) head_q <= wr_data;
          else tail_q <= wr_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          // With one entry left the head just goes invalid; its data stays put.
          if (count_q == 2'd2) head_q <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= wr_data;
          end else begin
            head_q <= tail_q;
            tail_q <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data = head_q;
  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);

endmodule

// File: rtl/pool_window_reader.sv
// Walks a row-major feature-map bank in KxK window order and streams pixels to the pool
// over valid/ready; reads are credit-limited so the 2-entry output FIFO never overflows.
module pool_window_reader
  import pool_window_reader_pkg::*;
#(
  parameter int unsigned IMG_W  = 111,
  parameter int unsigned IMG_H  = 111,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 2,
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          o_win_last,
  output logic          o_frame_last
);

  localparam int unsigned OutW = out_dim(IMG_W, K, STRIDE);
  localparam int unsigned OutH = out_dim(IMG_H, K, STRIDE);

  localparam logic [CntW-1:0] KLast  = CntW'(K - 1);
  localparam logic [CntW-1:0] OwLast = CntW'(OutW - 1);
  localparam logic [CntW-1:0] OhLast = CntW'(OutH - 1);

  localparam logic [AW-1:0] StepX   = AW'(STRIDE);
  localparam logic [AW-1:0] StepKy  = AW'(IMG_W);
  localparam logic [AW-1:0] StepRow = AW'(STRIDE * IMG_W);

  state_e          state_q;
  logic [CntW-1:0] kx_q, ky_q, ox_q, oy_q;
  logic [AW-1:0]   row_base_q;  // first pixel of the current window row
  logic [AW-1:0]   win_base_q;  // first pixel of the current window
  logic [AW-1:0]   row_ptr_q;   // first pixel of the current ky row inside the window
  logic            busy_q;
  logic            done_q;
  logic            rd_en_q;
  logic [AW-1:0]   rd_addr_q;
  logic            win_tag_q;
  logic            frame_tag_q;

  logic            fifo_full;
  logic            fifo_empty;
  logic [DW+1:0]   fifo_head;
  logic            pop;
  logic [1:0]      occ;
  logic [1:0]      used;
  logic            issue;
  logic            win_end;
  logic            row_end;
  logic            frame_end;
  logic            drain_clear;

  assign pop = o_valid && o_ready;
  assign occ = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);

  // Credits held by stored beats plus the read in flight; a beat leaving this cycle frees
  // its credit in time for the next issue, which keeps one beat per cycle when o_ready=1.
  assign used  = occ + {1'b0, rd_en_q} - {1'b0, pop};
  assign issue = (state_q == StRun) && (used < 2'd2);

  assign win_end   = (kx_q == KLast) && (ky_q == KLast);
  assign row_end   = (ox_q == OwLast);
  assign frame_end = win_end && row_end && (oy_q == OhLast);

  assign drain_clear = !rd_en_q && (fifo_empty || ((occ == 2'd1) && pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      kx_q        <= '0;
      ky_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      row_base_q  <= '0;
      win_base_q  <= '0;
      row_ptr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      win_tag_q   <= 1'b0;
      frame_tag_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            row_base_q <= '0;
            win_base_q <= '0;
            row_ptr_q  <= '0;
          end
        end
        StRun: begin
          busy_q <= 1'b1;
          if (issue) begin
            rd_en_q     <= 1'b1;
            rd_addr_q   <= row_ptr_q + AW'(kx_q);
            win_tag_q   <= win_end;
            frame_tag_q <= frame_end;
            if (kx_q == KLast) begin
              kx_q <= '0;
              if (ky_q == KLast) begin
                ky_q <= '0;
                if (row_end) begin
                  ox_q       <= '0;
                  oy_q       <= oy_q + CntW'(1);
                  row_base_q <= row_base_q + StepRow;
                  win_base_q <= row_base_q + StepRow;
                  row_ptr_q  <= row_base_q + StepRow;
                end else begin
                  ox_q       <= ox_q + CntW'(1);
                  win_base_q <= win_base_q + StepX;
                  row_ptr_q  <= win_base_q + StepX;
                end
              end else begin
                ky_q      <= ky_q + CntW'(1);
                row_ptr_q <= row_ptr_q + StepKy;
              end
            end else begin
              kx_q <= kx_q + CntW'(1);
            end
            if (frame_end) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (drain_clear) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // rd_data belongs to the read strobed in the previous cycle, tagged from the same issue.
  pool_skid_fifo #(
    .Width(DW + 2)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (rd_en_q),
    .wr_data({frame_tag_q, win_tag_q, rd_data}),
    .rd_en  (pop),
    .rd_data(fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign o_valid      = !fifo_empty;
  assign o_data       = fifo_head[DW-1:0];
  assign o_win_last   = fifo_head[DW];
  assign o_frame_last = fifo_head[DW+1];

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    rd_en_q |-> !(fifo_full && !pop));

endmodule

// File: doc/pool_window_reader.md
# pool_window_reader

Read-side sequencer for the conv1 pooling banks. The writer fills a bank row-major with an `IMG_H`×`IMG_W` feature map (address 0 = pixel (0,0), address `IMG_W*IMG_H-1` = last pixel). This block walks that stored map in K×K window order with a fixed stride, issues synchronous bank reads, and streams pixels to the max-pool datapath over a valid/ready handshake with window and frame delimiters. It replaces free-running address sharing between bank and pool, so the pool can stall without losing data.

## Interface
- `IMG_W`, default 111: stored map width in pixels.
- `IMG_H`, default 111: stored map height in pixels.
- `K`, default 3: window size, K×K.
- `STRIDE`, default 2: window step in x and y.
- `DW`, default 16: pixel width.
- `AW`, default 32: bank address width.

Ports (`clk` and `rst` first):
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to read one frame; ignored unless idle.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the frame's last beat is accepted.
- `rd_en` out 1: bank read strobe.
- `rd_addr` out AW: bank read address.
- `rd_data` in DW: bank data, valid exactly 1 cycle after `rd_en`.
- `o_data` out DW: pixel to pool.
- `o_valid` out 1: `o_data` valid.
- `o_ready` in 1: consumer accepts the beat when `o_valid && o_ready`.
- `o_win_last` out 1: beat is element K×K-1 of its window.
- `o_frame_last` out 1: beat is the last element of the last window.

## Operation
- Output dimensions: O_W = (IMG_W-K)/STRIDE+1 and O_H = (IMG_H-K)/STRIDE+1, using integer division. Defaults give 55×55 = 3025 windows and 27225 beats.
- Order: windows row-major over (oy, ox). Inside each window, row-major over (ky, kx).
- Address = (oy*STRIDE+ky)*IMG_W + ox*STRIDE + kx.
- Addresses are formed incrementally with no multiplier:
  - `win_base` advances by STRIDE per window.
  - At the end of a window row, `win_base` becomes `row_base + STRIDE*IMG_W`.
  - `row_ptr` advances by IMG_W per ky.
- All address arithmetic is AW-bit unsigned. Overflow cannot occur for legal parameters.
- FSM states:
  - IDLE: `start` moves to RUN and loads all counters and bases to 0.
  - RUN: issues reads. After the final address is issued, moves to DRAIN.
  - DRAIN: waits until the skid buffer is empty and no read is in flight, then moves to DONE.
  - DONE: lasts 1 cycle, drives `done`=1, then returns to IDLE.
- Flow control: a 2-entry skid FIFO sits on the output.
  - `rd_en` is asserted only when (FIFO occupancy + reads in flight) < 2 in RUN.
  - `rd_data` is written into the FIFO one cycle after `rd_en`.
  - `o_win_last` and `o_frame_last` tags travel with the read through a 1-cycle tag pipe.
- `start` while `busy` is ignored; the current frame is unaffected.
- `o_ready` low stalls issue once credits are exhausted. No beat is dropped or duplicated.
- Reset mid-frame: FSM returns to IDLE, counters and FIFO clear, and any in-flight `rd_data` is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `o_valid`=0, `o_data`=0, `o_win_last`=0, `o_frame_last`=0.
- `start` sampled high at edge N: `busy`=1 and `rd_en`=1 with `rd_addr`=0 after edge N+1. `o_valid`=1 with pixel 0 after edge N+2.
- With `o_ready` held at 1, one beat per cycle is sustained with no bubbles.
- `done` is high in the cycle after the `o_frame_last` beat is accepted. `busy` falls in the same cycle `done` is high.
- `o_data` and the tag outputs are held stable while `o_valid && !o_ready`.

## Structure
- Shared package:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Constant functions `out_dim(size, k, stride)` and `frame_beats()`, reused by the pool and the next-layer reader.
- Sub-module `pool_skid_fifo`: a 2-entry DW+2-bit FIFO with full/empty and registered outputs. The top level holds the FSM, counters and address bases.

## Test plan
- Defaults, `o_ready`=1: first 9 addresses are 0,1,2,111,112,113,222,223,224. Second window starts at 2. Last window addresses are 12096…12320. Exactly 27225 beats, 3025 `o_win_last` pulses, and one `o_frame_last`; `done` follows 1 cycle after the last beat.
- `IMG_W`=`IMG_H`=5, K=3, STRIDE=2: 4 windows with bases 0, 2, 10, 12. The bank model returns data = address, and `o_data` must equal the expected address sequence.
- Random `o_ready` at 30% duty: the output sequence is identical to the `o_ready`=1 run, `o_data` is stable while stalled, and `rd_en` never issues with 2 credits used.
- `start` pulsed again at beat 100: ignored, with no change in the beat count or address sequence.
- `rst` asserted at beat 5000 with a read in flight: all outputs go to reset values immediately. A new `start` then replays from address 0 with no stale beat.
- `o_ready`=0 for 50 cycles right after `start`: exactly 2 `rd_en` pulses occur. The first `o_data` is pixel 0 and is held until `o_ready` rises.
